ext_mem_responder: RTL and testbench



---
 rtl/ext_mem_pkg.sv | 23 ++
 rtl/ext_mem_channel_ctrl.sv | 142 ++++++++++++++
 rtl/ext_mem_responder.sv | 97 +++++++++
 tb/tb_ext_mem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_pkg.sv
// Shared types and helpers for the external-memory responder: channel FSM states,
// per-channel field widths and the write-mask function.
package ext_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam int unsigned ADDR_SLICE = 7;
  localparam int unsigned DATA_SLICE = 8;
  localparam int unsigned SIZE_SLICE = 4;

  // Low `size` bits set; sizes of a full byte or more saturate to all ones.
  function automatic logic [DATA_SLICE-1:0] size_mask(input logic [SIZE_SLICE-1:0] size);
    logic [15:0] full;
    full = (16'd1 << size) - 16'd1;
    if (size >= SIZE_SLICE'(DATA_SLICE)) return '1;
    return full[DATA_SLICE-1:0];
  endfunction

endpackage

// File: rtl/ext_mem_channel_ctrl.sv
// One memory channel: range decode, IDLE/READ/WRITE sequencing with a wait counter,
// read-byte hold stage, write capture and the sticky oe+we error flag.
//
//   state    | meaning
//   ST_IDLE  | no transaction; a valid in-range request is accepted at the edge
//   ST_READ  | read accepted, counting to READ_LAT-1, byte already captured
//   ST_WRITE | write accepted, counting to WRITE_LAT-1, commit on the closing edge
module ext_mem_channel_ctrl
  import ext_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_SLICE,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MEMSIZE   = 32,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1,
  parameter int unsigned IDX_W     = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  oe,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_SLICE-1:0] wdata,
  input  logic [SIZE_SLICE-1:0] size,
  output logic [IDX_W-1:0]      req_idx,
  input  logic [DATA_SLICE-1:0] rd_byte,
  output logic                  rdy,
  output logic [DATA_SLICE-1:0] rdata,
  output logic                  commit_en,
  output logic [IDX_W-1:0]      commit_idx,
  output logic [DATA_SLICE-1:0] commit_data,
  output logic [DATA_SLICE-1:0] commit_mask,
  output logic                  err_both
);

  localparam int unsigned MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_LAT - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_SLICE-1:0] wdata_q, wdata_d;
  logic [DATA_SLICE-1:0] mask_q, mask_d;
  logic [DATA_SLICE-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0] addr_ext, offset;
  logic        in_range, accept_rd, accept_wr, done, start;

  always_comb begin
    addr_ext  = 32'(addr);
    offset    = addr_ext - BASE_ADDR;
    in_range  = (addr_ext >= BASE_ADDR) && (offset < MEMSIZE);
    req_idx   = IDX_W'(offset);
    accept_rd = oe && !we && in_range;
    accept_wr = we && !oe && in_range;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    err_d   = err_q | (oe & we);
    start   = 1'b0;
    unique case (state_q)
      ST_IDLE: start = 1'b1;
      ST_READ: begin
        if (done) start = 1'b1;
        else if (!oe) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      ST_WRITE: begin
        if (done) start = 1'b1;
        else if (!we) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // The read byte is sampled at acceptance; reads never overlap within a channel,
    // so holding it until the ready cycle equals a READ_LAT-1 deep delay line.
    if (start) begin
      cnt_d = '0;
      if (accept_rd) begin
        state_d = ST_READ;
        idx_d   = req_idx;
        rdata_d = rd_byte;
      end else if (accept_wr) begin
        state_d = ST_WRITE;
        idx_d   = req_idx;
        wdata_d = wdata;
        mask_d  = size_mask(size);
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    done        = ((state_q == ST_READ)  && (cnt_q == RD_LAST)) ||
                  ((state_q == ST_WRITE) && (cnt_q == WR_LAST));
    rdy         = done;
    rdata       = ((state_q == ST_READ) && done) ? rdata_q : '0;
    commit_en   = (state_q == ST_WRITE) && done;
    commit_idx  = idx_q;
    commit_data = wdata_q;
    commit_mask = mask_q;
    err_both    = err_q;
  end

endmodule

// File: rtl/ext_mem_responder.sv
// Fixed-latency byte memory serving the accelerator's master RAM port on independent
// channels; owns the shared array, write arbitration and output packing.
module ext_mem_responder
  import ext_mem_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned ADDR_W    = ADDR_SLICE,
  parameter int unsigned DATA_W    = DATA_SLICE,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MEMSIZE   = 32,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            Mout_oe_ram,
  input  logic [CHANNELS-1:0]            Mout_we_ram,
  input  logic [CHANNELS*ADDR_W-1:0]     Mout_addr_ram,
  input  logic [CHANNELS*DATA_W-1:0]     Mout_Wdata_ram,
  input  logic [CHANNELS*SIZE_SLICE-1:0] Mout_data_ram_size,
  output logic [CHANNELS*DATA_W-1:0]     M_Rdata_ram,
  output logic [CHANNELS-1:0]            M_DataRdy,
  input  logic                           ld_we,
  input  logic [ADDR_W-1:0]              ld_addr,
  input  logic [DATA_W-1:0]              ld_data,
  output logic [CHANNELS-1:0]            err_both
);

  localparam int unsigned IDX_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

  logic [DATA_W-1:0]   mem_q [MEMSIZE];
  logic [DATA_W-1:0]   mem_d [MEMSIZE];
  logic [IDX_W-1:0]    req_idx     [CHANNELS];
  logic [IDX_W-1:0]    commit_idx  [CHANNELS];
  logic [DATA_W-1:0]   rd_byte     [CHANNELS];
  logic [DATA_W-1:0]   commit_data [CHANNELS];
  logic [DATA_W-1:0]   commit_mask [CHANNELS];
  logic [CHANNELS-1:0] commit_en;
  logic                ld_in_range;
  logic [IDX_W-1:0]    ld_idx;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign rd_byte[c] = mem_q[req_idx[c]];

    ext_mem_channel_ctrl #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR),
      .MEMSIZE   (MEMSIZE),
      .READ_LAT  (READ_LAT),
      .WRITE_LAT (WRITE_LAT),
      .IDX_W     (IDX_W)
    ) u_ctrl (
      .clock       (clock),
      .reset       (reset),
      .oe          (Mout_oe_ram[c]),
      .we          (Mout_we_ram[c]),
      .addr        (Mout_addr_ram[c*ADDR_W +: ADDR_W]),
      .wdata       (Mout_Wdata_ram[c*DATA_W +: DATA_W]),
      .size        (Mout_data_ram_size[c*SIZE_SLICE +: SIZE_SLICE]),
      .req_idx     (req_idx[c]),
      .rd_byte     (rd_byte[c]),
      .rdy         (M_DataRdy[c]),
      .rdata       (M_Rdata_ram[c*DATA_W +: DATA_W]),
      .commit_en   (commit_en[c]),
      .commit_idx  (commit_idx[c]),
      .commit_data (commit_data[c]),
      .commit_mask (commit_mask[c]),
      .err_both    (err_both[c])
    );
  end

  always_comb begin
    ld_in_range = 32'(ld_addr) < MEMSIZE;
    ld_idx      = ld_addr[IDX_W-1:0];
  end

  // Later writers overwrite earlier ones: preload < channel 0 < channel 1.
  // Every merge uses the pre-edge contents, so a same-edge read sees the old byte.
  always_comb begin
    mem_d = mem_q;
    if (!reset) begin
      if (ld_we && ld_in_range) mem_d[ld_idx] = ld_data;
      for (int c = 0; c < CHANNELS; c++) begin
        if (commit_en[c]) begin
          mem_d[commit_idx[c]] = (commit_data[c] & commit_mask[c]) |
                                 (mem_q[commit_idx[c]] & ~commit_mask[c]);
        end
      end
    end
  end

  // Contents deliberately survive reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_ext_mem_responder.sv
// Scoreboard bench for ext_mem_responder: expected ready-cycle bytes are queued per
// channel at request time and popped by a negedge monitor.
module tb_ext_mem_responder;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  Mout_oe_ram, Mout_we_ram;
  logic [13:0] Mout_addr_ram;
  logic [15:0] Mout_Wdata_ram;
  logic [7:0]  Mout_data_ram_size;
  logic [15:0] M_Rdata_ram;
  logic [1:0]  M_DataRdy;
  logic        ld_we;
  logic [6:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [1:0]  err_both;

  int          n_vec = 0;
  int          n_mis = 0;
  logic [7:0]  model [32];
  logic [7:0]  exp_q0 [$];
  logic [7:0]  exp_q1 [$];
  bit          mon_en = 1'b0;

  always #5 clock = ~clock;

  ext_mem_responder #(
    .CHANNELS  (2),
    .ADDR_W    (7),
    .DATA_W    (8),
    .BASE_ADDR (0),
    .MEMSIZE   (32),
    .READ_LAT  (RD_LAT),
    .WRITE_LAT (WR_LAT)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .Mout_oe_ram        (Mout_oe_ram),
    .Mout_we_ram        (Mout_we_ram),
    .Mout_addr_ram      (Mout_addr_ram),
    .Mout_Wdata_ram     (Mout_Wdata_ram),
    .Mout_data_ram_size (Mout_data_ram_size),
    .M_Rdata_ram        (M_Rdata_ram),
    .M_DataRdy          (M_DataRdy),
    .ld_we              (ld_we),
    .ld_addr            (ld_addr),
    .ld_data            (ld_data),
    .err_both           (err_both)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] tb_mask(input int size);
    int m;
    if (size >= 8) return 8'hFF;
    m = (1 << size) - 1;
    return m[7:0];
  endfunction

  task automatic model_write(input int addr, input logic [7:0] data, input int size);
    logic [7:0] m;
    m = tb_mask(size);
    model[addr] = (data & m) | (model[addr] & ~m);
  endtask

  task automatic preload(input int addr, input logic [7:0] d);
    @(negedge clock);
    ld_we   = 1'b1;
    ld_addr = 7'(addr);
    ld_data = d;
    @(negedge clock);
    ld_we = 1'b0;
    model[addr] = d;
  endtask

  // One handshake on channel ch; exp_rd is the byte a read must return.
  task automatic xact(input int ch, input bit is_wr, input int addr,
                      input logic [7:0] wdata, input logic [3:0] size, input logic [7:0] exp_rd);
    int n;
    bit got;
    @(negedge clock);
    Mout_addr_ram[ch*7 +: 7]      = 7'(addr);
    Mout_Wdata_ram[ch*8 +: 8]     = wdata;
    Mout_data_ram_size[ch*4 +: 4] = size;
    if (is_wr) Mout_we_ram[ch] = 1'b1;
    else       Mout_oe_ram[ch] = 1'b1;
    if (ch == 0) exp_q0.push_back(is_wr ? 8'h00 : exp_rd);
    else         exp_q1.push_back(is_wr ? 8'h00 : exp_rd);
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clock);
      n++;
      got = M_DataRdy[ch];
    end
    chk($sformatf("%s_latency_ch%0d", is_wr ? "wr" : "rd", ch), 32'(n), is_wr ? WR_LAT : RD_LAT);
    Mout_oe_ram[ch] = 1'b0;
    Mout_we_ram[ch] = 1'b0;
  endtask

  always @(negedge clock) begin
    logic [7:0] got_b, exp_b;
    if (mon_en) begin
      for (int c = 0; c < 2; c++) begin
        got_b = M_Rdata_ram[c*8 +: 8];
        if (M_DataRdy[c]) begin
          if ((c == 0 && exp_q0.size() == 0) || (c == 1 && exp_q1.size() == 0)) begin
            chk($sformatf("spurious_rdy_ch%0d", c), 32'(M_DataRdy[c]), 0);
          end else begin
            exp_b = (c == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("rdata_ch%0d", c), 32'(got_b), 32'(exp_b));
          end
        end else begin
          chk($sformatf("idle_rdata_ch%0d", c), 32'(got_b), 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    reset              = 1'b1;
    Mout_oe_ram        = 2'b11;
    Mout_we_ram        = 2'b00;
    Mout_addr_ram      = '0;
    Mout_Wdata_ram     = '0;
    Mout_data_ram_size = '0;
    ld_we              = 1'b0;
    ld_addr            = '0;
    ld_data            = '0;

    // reset held three cycles with both reads requested
    @(posedge clock);
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_rdy", 32'(M_DataRdy), 0);
      chk("rst_rdata", 32'(M_Rdata_ram), 0);
      chk("rst_err", 32'(err_both), 0);
    end
    Mout_oe_ram = 2'b00;
    reset       = 1'b0;

    // preload then read
    preload(5, 8'hA5);
    xact(0, 1'b0, 5, 8'h00, 4'd0, model[5]);

    // partial write, then read back merged byte
    xact(0, 1'b1, 5, 8'h3C, 4'd4, 8'h00);
    model_write(5, 8'h3C, 4);
    xact(0, 1'b0, 5, 8'h00, 4'd0, model[5]);

    // size 0 leaves the byte alone, size above 8 writes the full byte
    preload(10, 8'h99);
    preload(11, 8'h00);
    xact(1, 1'b1, 10, 8'h55, 4'd0, 8'h00);
    model_write(10, 8'h55, 0);
    xact(1, 1'b1, 11, 8'h5A, 4'd12, 8'h00);
    model_write(11, 8'h5A, 12);
    xact(1, 1'b0, 10, 8'h00, 4'd0, model[10]);
    xact(1, 1'b0, 11, 8'h00, 4'd0, model[11]);

    // both channels write the same byte in the same cycle
    fork
      xact(0, 1'b1, 7, 8'h11, 4'd8, 8'h00);
      xact(1, 1'b1, 7, 8'h22, 4'd8, 8'h00);
    join
    model_write(7, 8'h11, 8);
    model_write(7, 8'h22, 8);
    xact(0, 1'b0, 7, 8'h00, 4'd0, model[7]);

    // read accepted on the same edge that commits a write returns the old byte
    preload(20, 8'h3E);
    fork
      xact(1, 1'b1, 20, 8'hC4, 4'd8, 8'h00);
      begin
        @(negedge clock);
        xact(0, 1'b0, 20, 8'h00, 4'd0, model[20]);
      end
    join
    model_write(20, 8'hC4, 8);
    xact(0, 1'b0, 20, 8'h00, 4'd0, model[20]);

    // out-of-range read is ignored, then oe+we sets the sticky error
    @(negedge clock);
    Mout_addr_ram[13:7] = 7'd40;
    Mout_oe_ram[1]      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("oor_rdy_ch1", 32'(M_DataRdy[1]), 0);
    end
    chk("err_before", 32'(err_both), 0);
    Mout_addr_ram[13:7] = 7'd3;
    Mout_we_ram[1]      = 1'b1;
    @(negedge clock);
    chk("err_set", 32'(err_both), 32'h2);
    Mout_oe_ram = 2'b00;
    Mout_we_ram = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("err_sticky", 32'(err_both), 32'h2);
    end

    // reset mid-read; preload attempted during reset is ignored
    preload(12, 8'h00);
    @(negedge clock);
    Mout_addr_ram[6:0] = 7'd5;
    Mout_oe_ram[0]     = 1'b1;
    @(negedge clock);
    chk("pre_rst_rdy", 32'(M_DataRdy), 0);
    reset          = 1'b1;
    Mout_oe_ram[0] = 1'b0;
    ld_we          = 1'b1;
    ld_addr        = 7'd12;
    ld_data        = 8'h77;
    @(negedge clock);
    reset = 1'b0;
    ld_we = 1'b0;
    chk("rst_mid_rdy", 32'(M_DataRdy), 0);
    chk("rst_err_clr", 32'(err_both), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("post_rst_rdy", 32'(M_DataRdy), 0);
    end
    xact(0, 1'b0, 5, 8'h00, 4'd0, model[5]);
    xact(1, 1'b0, 12, 8'h00, 4'd0, model[12]);

    repeat (2) @(negedge clock);
    chk("q0_drained", 32'(exp_q0.size()), 0);
    chk("q1_drained", 32'(exp_q1.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
